// File: rtl/pw_psum_accum_buffer.sv
// Pointwise partial-sum tile buffer: per-lane in-place accumulation, 2-cycle registered read, clear sweep.
// Optional feature macro: PW_PSUM_SAT_EN (saturating per-lane add plus sticky sat_flag).
module pw_psum_accum_buffer #(
    parameter int DEPTH = 128,
    parameter int LANES = 32,
    parameter int ACC_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       acc_valid,
    input  logic                       acc_first,
    input  logic [$clog2(DEPTH)-1:0]   acc_addr,
    input  logic [LANES*ACC_W-1:0]     acc_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [LANES*ACC_W-1:0]     rd_data,
    output logic                       rd_valid,
    input  logic                       clr_start,
    output logic                       busy,
    output logic                       drop_err,
    output logic                       sat_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = LANES * ACC_W;

    // Handshake: acc_valid and rd_en are fire-and-forget (no ready); an accumulate is taken
    // on any edge where busy is low, and rd_valid marks rd_data exactly two edges after rd_en.

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} clr_state_e;

    typedef struct packed {
        clr_state_e      state;
        logic [AW-1:0]   cnt;
    } clr_dbg_t;

    clr_dbg_t          clr_q;

    logic [DW-1:0]     mem [DEPTH];

    logic              s1_v;
    logic              s1_first;
    logic [AW-1:0]     s1_addr;
    logic [DW-1:0]     s1_data;

    logic              s2_v;
    logic              s2_first;
    logic [AW-1:0]     s2_addr;
    logic [DW-1:0]     s2_data;
    logic [DW-1:0]     s2_old;
    logic [DW-1:0]     s2_sum;

    logic              rd_v1;
    logic              rd_v2;
    logic [AW-1:0]     rd_a1;
    logic [DW-1:0]     rd_q;

    logic              acc_take;
    logic              fwd;
    logic              clr_we;

    assign acc_take = acc_valid && !busy;
    assign fwd      = s2_v && (s2_addr == s1_addr);
    assign clr_we   = (clr_q.state == CLEAR);

`ifdef PW_PSUM_SAT_EN
    logic [LANES-1:0]  lane_ovf;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [ACC_W-1:0] a;
        logic [ACC_W-1:0] b;
        logic [ACC_W-1:0] s;

        assign a = s2_old[g*ACC_W +: ACC_W];
        assign b = s2_data[g*ACC_W +: ACC_W];
`ifdef PW_PSUM_SAT_EN
        logic [ACC_W-1:0] raw;
        assign raw         = a + b;
        // Same-sign operands producing an opposite-sign result is the only overflow case.
        assign lane_ovf[g] = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
        assign s           = lane_ovf[g] ? {a[ACC_W-1], {(ACC_W-1){~a[ACC_W-1]}}} : raw;
`else
        assign s = a + b;
`endif
        assign s2_sum[g*ACC_W +: ACC_W] = s2_first ? b : s;
    end

    // Clear sequencer: drain in-flight accumulates, then sweep zeros over every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q.state <= IDLE;
            clr_q.cnt   <= '0;
            busy        <= 1'b0;
        end else begin
            case (clr_q.state)
                IDLE: begin
                    if (clr_start) begin
                        clr_q.state <= DRAIN;
                        busy        <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!s1_v && !s2_v) begin
                        clr_q.state <= CLEAR;
                        clr_q.cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_q.cnt == AW'(DEPTH - 1)) begin
                        clr_q.state <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        clr_q.cnt <= clr_q.cnt + AW'(1);
                    end
                end
                default: begin
                    clr_q.state <= IDLE;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_addr  <= '0;
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_addr  <= '0;
            drop_err <= 1'b0;
        end else begin
            s1_v <= acc_take;
            if (acc_take) begin
                s1_first <= acc_first;
                s1_addr  <= acc_addr;
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_first <= s1_first;
                s2_addr  <= s1_addr;
            end
            if (acc_valid && busy) begin
                drop_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1    <= 1'b0;
            rd_a1    <= '0;
            rd_v2    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_v1 <= rd_en;
            if (rd_en) begin
                rd_a1 <= rd_addr;
            end
            rd_v2    <= rd_v1;
            rd_valid <= rd_v2;
            if (rd_v2) begin
                rd_data <= rd_q;
            end
        end
    end

    // Storage and datapath registers carry no reset; the control valids above gate them.
    always_ff @(posedge clk) begin
        if (acc_take) begin
            s1_data <= acc_data;
        end
        if (s1_v) begin
            s2_data <= s1_data;
            // A sum still waiting in S2 has not reached mem yet, so hand it over directly.
            s2_old  <= fwd ? s2_sum : mem[s1_addr];
        end
        if (rd_v1) begin
            rd_q <= mem[rd_a1];
        end
        if (clr_we) begin
            mem[clr_q.cnt] <= '0;
        end else if (s2_v) begin
            mem[s2_addr] <= s2_sum;
        end
    end

`ifdef PW_PSUM_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (s2_v && !s2_first && (|lane_ovf)) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_pw_psum_accum_buffer.sv
// Bench for pw_psum_accum_buffer: directed scenarios plus random traffic against a
// visibility-time reference model (write lands at a known edge; reads see writes at or before their sample edge).
module tb_pw_psum_accum_buffer;

    localparam int DEPTH = 16;
    localparam int LANES = 4;
    localparam int ACC_W = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = LANES * ACC_W;
    localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

    logic            clk = 1'b0;
    logic            rst_n;
    logic            acc_valid;
    logic            acc_first;
    logic [AW-1:0]   acc_addr;
    logic [DW-1:0]   acc_data;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            clr_start;
    logic            busy;
    logic            drop_err;
    logic            sat_flag;

    pw_psum_accum_buffer #(.DEPTH(DEPTH), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .acc_valid(acc_valid), .acc_first(acc_first), .acc_addr(acc_addr), .acc_data(acc_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_start(clr_start), .busy(busy), .drop_err(drop_err), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int            at;
        bit            zero;
        bit            first;
        int            addr;
        logic [DW-1:0] data;
    } op_t;

    op_t           op_q[$];
    logic [DW-1:0] exp_q[$];
    int            exp_due_q[$];
    bit            exp_known_q[$];

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    int            edge_n = 0;
    bit            busy_prev = 0;
    bit            clr_on = 0;
    int            busy_end = 0;
    int            last_acc = -100;
    bit            e_drop = 0;
    bit            e_sat = 0;
    logic [DW-1:0] hold = '0;
    bit            hold_known = 1;

    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                               output bit sat);
        logic [DW-1:0] r;
        longint a, b, s;
        sat = 0;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            a = longint'($signed(x[i*ACC_W +: ACC_W]));
            b = longint'($signed(y[i*ACC_W +: ACC_W]));
            s = a + b;
`ifdef PW_PSUM_SAT_EN
            if (s > MAXV) begin s = MAXV; sat = 1; end
            else if (s < MINV) begin s = MINV; sat = 1; end
`endif
            r[i*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] splat(input logic [ACC_W-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_idx(input bit neg);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = neg ? ACC_W'(-i) : ACC_W'(i);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = $urandom;
        return r;
    endfunction

    // Called #1 after each sampling edge, while the inputs sampled at that edge are still applied.
    task automatic evaluate();
        bit            s, exp_v;
        int            c;
        op_t           o;
        logic [DW-1:0] d;
        bit            k;
        if (acc_valid && busy_prev) e_drop = 1;
        if (acc_valid && !busy_prev) begin
            op_q.push_back('{edge_n + 2, 1'b0, acc_first, int'(acc_addr), acc_data});
            last_acc = edge_n;
        end
        if (clr_start && !busy_prev) begin
            c = (edge_n + 1 > last_acc + 3) ? edge_n + 1 : last_acc + 3;
            for (int a = 0; a < DEPTH; a++) op_q.push_back('{c + 1 + a, 1'b1, 1'b0, a, '0});
            clr_on   = 1;
            busy_end = c + DEPTH;
        end
        if (clr_on && edge_n >= busy_end) clr_on = 0;
        while (op_q.size() > 0 && op_q[0].at <= edge_n) begin
            o = op_q.pop_front();
            if (o.zero || o.first) begin
                m_mem[o.addr]   = o.data;
                m_known[o.addr] = 1;
            end else begin
                m_mem[o.addr] = lane_add(m_mem[o.addr], o.data, s);
                if (s && m_known[o.addr]) e_sat = 1;
            end
        end
        if (rd_en) begin
            exp_q.push_back(m_mem[rd_addr]);
            exp_due_q.push_back(edge_n + 2);
            exp_known_q.push_back(m_known[rd_addr]);
        end
        exp_v = (exp_due_q.size() > 0) && (exp_due_q[0] == edge_n);
        check("rd_valid", rd_valid, exp_v);
        if (exp_v) begin
            d = exp_q.pop_front();
            k = exp_known_q.pop_front();
            void'(exp_due_q.pop_front());
            if (k) check("rd_data", rd_data, d);
            hold       = d;
            hold_known = k;
        end else if (hold_known) begin
            check("rd_hold", rd_data, hold);
        end
        check("busy", busy, clr_on);
        check("drop_err", drop_err, e_drop);
        check("sat_flag", sat_flag, e_sat);
        busy_prev = clr_on;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit av, input bit af, input int aa, input logic [DW-1:0] ad,
                        input bit re, input int ra, input bit cs);
        acc_valid = av;
        acc_first = af;
        acc_addr  = AW'(aa);
        acc_data  = ad;
        rd_en     = re;
        rd_addr   = AW'(ra);
        clr_start = cs;
        @(posedge clk);
        edge_n++;
        #1;
        evaluate();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        step(0, 0, 0, '0, 1, a, 0);
    endtask

    task automatic model_reset();
        op_q.delete();
        exp_q.delete();
        exp_due_q.delete();
        exp_known_q.delete();
        for (int a = 0; a < DEPTH; a++) m_known[a] = 0;
        clr_on     = 0;
        busy_prev  = 0;
        e_drop     = 0;
        e_sat      = 0;
        hold       = '0;
        hold_known = 1;
        last_acc   = -100;
    endtask

    task automatic reset_mid(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_rd_data"}, rd_data, '0);
        check({tag, "_rd_valid"}, rd_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_drop_err"}, drop_err, 1'b0);
        check({tag, "_sat_flag"}, sat_flag, 1'b0);
        acc_valid = 0; rd_en = 0; clr_start = 0;
        repeat (2) begin @(posedge clk); edge_n++; end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit av, af, re, cs;
        int aa, ra;
        rst_n = 1'b0;
        acc_valid = 0; acc_first = 0; acc_addr = '0; acc_data = '0;
        rd_en = 0; rd_addr = '0; clr_start = 0;
        model_reset();
        #3;
        check("reset_rd_data", rd_data, '0);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_drop_err", drop_err, 1'b0);
        check("reset_sat_flag", sat_flag, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Overwrite then read back three cycles later.
        step(1, 1, 5, splat(7), 0, 0, 0);
        idle(2);
        rd(5);
        idle(3);

        // Back-to-back forwarding to one address, then per-lane independence.
        step(1, 1, 9, splat(10), 0, 0, 0);
        step(1, 0, 9, splat(1), 0, 0, 0);
        step(1, 0, 9, splat(2), 0, 0, 0);
        step(1, 0, 9, splat(3), 0, 0, 0);
        idle(2);
        rd(9);
        idle(3);
        step(1, 1, 9, lane_idx(0), 0, 0, 0);
        step(1, 0, 9, lane_idx(1), 0, 0, 0);
        idle(2);
        rd(9);
        idle(3);

        // Interleaved addresses with a concurrent read stream of entry 4.
        step(1, 1, 3, splat(100), 1, 4, 0);
        step(1, 1, 4, splat(200), 1, 4, 0);
        step(1, 0, 3, splat(5), 1, 4, 0);
        step(1, 0, 4, splat(5), 1, 4, 0);
        for (int i = 0; i < 3; i++) rd(4);
        rd(3);
        idle(3);

        // Fill every entry, then clear with two accumulates still in flight.
        for (int a = 0; a < DEPTH; a++) step(1, 1, a, splat(32'h55), 0, 0, 0);
        step(1, 0, 2, splat(1), 0, 0, 0);
        step(1, 0, 3, splat(1), 0, 0, 1);
        for (int i = 0; i < DEPTH + 6; i++) begin
            ra = (i < 4) ? 2 + (i % 2) : $urandom_range(0, DEPTH - 1);
            step((i % 3) == 0, 1, $urandom_range(0, DEPTH - 1), rand_data(), 1, ra, i == 10);
        end
        for (int a = 0; a < DEPTH; a++) rd(a);
        idle(3);

        // Signed bounds.
        step(1, 1, 1, splat(32'h7FFF_FFFF), 0, 0, 0);
        step(1, 0, 1, splat(32'h0000_0001), 0, 0, 0);
        step(1, 1, 2, splat(32'h8000_0000), 0, 0, 0);
        step(1, 0, 2, splat(32'hFFFF_FFFF), 0, 0, 0);
        idle(2);
        rd(1);
        rd(2);
        idle(3);

        // Random traffic, biased toward a few addresses to exercise forwarding.
        for (int i = 0; i < 400; i++) begin
            av = ($urandom_range(0, 3) != 0);
            af = ($urandom_range(0, 3) == 0);
            aa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
            re = ($urandom_range(0, 1) == 1);
            ra = $urandom_range(0, DEPTH - 1);
            cs = ($urandom_range(0, 149) == 0);
            step(av, af, aa, rand_data(), re, ra, cs);
        end
        idle(DEPTH + 8);

        // Reset mid-accumulate, then a fresh accumulate and read.
        rd(9);
        idle(2);
        step(1, 1, 6, splat(9), 1, 5, 0);
        reset_mid("rst_acc");
        step(1, 1, 7, splat(32'h1234), 0, 0, 0);
        step(1, 0, 7, splat(32'h0101), 0, 0, 0);
        idle(2);
        rd(7);
        idle(3);

        // Reset mid-clear.
        step(0, 0, 0, '0, 0, 0, 1);
        idle(5);
        reset_mid("rst_clr");
        step(1, 1, 8, rand_data(), 0, 0, 0);
        idle(2);
        rd(8);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
